// File: rtl/dtb_pkg.sv
// Shared constants and the trace-mode state encoding for the Data Trace Buffer memory side.
package dtb_pkg;
  localparam int TRB_DEPTH      = 64;
  localparam int TRB_ADDR_BITS  = $clog2(TRB_DEPTH);
  localparam int TRB_DELAY_BITS = 8;
  localparam int TRB_WIDTH      = 32;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ARMED,
    SEQ_DELAY,
    SEQ_DONE
  } seq_state_e;
endpackage

// File: rtl/trb_ring_ptr.sv
// Ring-buffer pointer with clear/load/increment and a wrap pulse on the max->0 step.
module trb_ring_ptr #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr,
  output logic         o_wrap
);
  logic [W-1:0] r_ptr;

  // clear beats load beats increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_ptr <= '0;
    else if (i_clear)  r_ptr <= '0;
    else if (i_load)   r_ptr <= i_load_val;
    else if (i_inc)    r_ptr <= r_ptr + W'(1);
  end

  assign o_ptr  = r_ptr;
  assign o_wrap = i_inc & (r_ptr == '1);
endmodule

// File: rtl/trb_mem_sequencer.sv
// Memory-side controller of the trace buffer: trace-mode ring capture with post-trigger delay,
// or stream-mode host-fed FIFO serving Tracer load requests.
module trb_mem_sequencer
  import dtb_pkg::*;
#(
  parameter int DEPTH      = TRB_DEPTH,
  parameter int DELAY_BITS = TRB_DELAY_BITS
) (
  input  logic                     FPGA_CLK_I,
  input  logic                     RST_NI,
  input  logic                     EN_I,
  input  logic                     MODE_I,
  input  logic                     CLEAR_I,
  input  logic [DELAY_BITS-1:0]    DELAY_I,
  input  logic                     STORE_I,
  input  logic [TRB_WIDTH-1:0]     TRC_DATA_I,
  input  logic                     TRIG_I,
  input  logic                     REQ_I,
  output logic                     TRG_EVENT_O,
  output logic                     LOAD_O,
  output logic [TRB_WIDTH-1:0]     TRC_DATA_O,
  input  logic                     HOST_WE_I,
  input  logic [TRB_WIDTH-1:0]     HOST_DATA_I,
  input  logic                     HOST_RE_I,
  output logic [TRB_WIDTH-1:0]     HOST_DATA_O,
  output logic                     HOST_VALID_O,
  output logic [$clog2(DEPTH)-1:0] TRIG_ADDR_O,
  output logic                     FULL_O,
  output logic                     EMPTY_O,
  output logic                     DONE_O,
  output logic                     OVF_O,
  output logic                     MEM_WE_O,
  output logic [$clog2(DEPTH)-1:0] MEM_WADDR_O,
  output logic [TRB_WIDTH-1:0]     MEM_WDATA_O,
  output logic [$clog2(DEPTH)-1:0] MEM_RADDR_O,
  input  logic [TRB_WIDTH-1:0]     MEM_RDATA_I,
  output seq_state_e               DBG_STATE_O
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  seq_state_e    r_state, w_state_n;
  logic          r_mode_q;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_trig_addr;
  logic          r_wrapped;
  logic [CW-1:0] r_count;
  logic          r_pending;
  logic          r_ovf;
  logic          r_load;
  logic          r_host_valid;

  logic          w_restart, w_trace_act, w_stream_act;
  logic          w_trc_we, w_trig_hit, w_enter_done, w_host_rd;
  logic          w_full, w_empty, w_fifo_wr, w_fifo_rd;
  logic          w_wr_wrap, w_rd_wrap_unused;
  logic [AW-1:0] w_wr_ptr, w_rd_ptr, w_delay_clamp, w_rd_load_val;

  // A mode flip is seen as a mismatch against last cycle's mode and restarts everything.
  assign w_restart    = CLEAR_I | (MODE_I != r_mode_q);
  assign w_trace_act  = EN_I & ~MODE_I & ~w_restart;
  assign w_stream_act = EN_I &  MODE_I & ~w_restart;

  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_delay_clamp = (32'(DELAY_I) > 32'(DEPTH - 1)) ? AW'(DEPTH - 1) : AW'(DELAY_I);

  assign w_fifo_wr = w_stream_act & HOST_WE_I & ~w_full;
  assign w_fifo_rd = w_stream_act & r_pending & ~w_empty;

  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI)        r_state <= SEQ_IDLE;
    else if (w_restart) r_state <= SEQ_IDLE;
    else                r_state <= w_state_n;
  end

  always_comb begin
    w_state_n    = r_state;
    w_trc_we     = 1'b0;
    w_trig_hit   = 1'b0;
    w_enter_done = 1'b0;
    w_host_rd    = 1'b0;
    if (w_trace_act) begin
      case (r_state)
        SEQ_IDLE:  w_state_n = SEQ_ARMED;
        SEQ_ARMED: begin
          if (STORE_I) begin
            w_trc_we = 1'b1;
            if (TRIG_I) begin
              w_trig_hit = 1'b1;
              if (w_delay_clamp == '0) begin
                w_state_n    = SEQ_DONE;
                w_enter_done = 1'b1;
              end else begin
                w_state_n = SEQ_DELAY;
              end
            end
          end
        end
        SEQ_DELAY: begin
          if (STORE_I) begin
            w_trc_we = 1'b1;
            // the store that would take cnt to zero is the last one written
            if (r_cnt == AW'(1)) begin
              w_state_n    = SEQ_DONE;
              w_enter_done = 1'b1;
            end
          end
        end
        SEQ_DONE:  w_host_rd = HOST_RE_I;
        default:   w_state_n = SEQ_IDLE;
      endcase
    end
  end

  // Oldest word sits at the post-store write pointer once the ring has wrapped.
  assign w_rd_load_val = (r_wrapped | w_wr_wrap) ? (w_wr_ptr + AW'(1)) : '0;

  trb_ring_ptr #(.W(AW)) u_wr_ptr (
    .i_clk      (FPGA_CLK_I),
    .i_rst_n    (RST_NI),
    .i_clear    (w_restart),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_trc_we | w_fifo_wr),
    .o_ptr      (w_wr_ptr),
    .o_wrap     (w_wr_wrap)
  );

  trb_ring_ptr #(.W(AW)) u_rd_ptr (
    .i_clk      (FPGA_CLK_I),
    .i_rst_n    (RST_NI),
    .i_clear    (w_restart),
    .i_load     (w_enter_done),
    .i_load_val (w_rd_load_val),
    .i_inc      (w_host_rd | w_fifo_rd),
    .o_ptr      (w_rd_ptr),
    .o_wrap     (w_rd_wrap_unused)
  );

  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_mode_q     <= 1'b0;
      r_cnt        <= '0;
      r_trig_addr  <= '0;
      r_wrapped    <= 1'b0;
      r_count      <= '0;
      r_pending    <= 1'b0;
      r_ovf        <= 1'b0;
      r_load       <= 1'b0;
      r_host_valid <= 1'b0;
    end else begin
      r_mode_q <= MODE_I;
      if (w_restart) begin
        r_cnt        <= '0;
        r_trig_addr  <= '0;
        r_wrapped    <= 1'b0;
        r_count      <= '0;
        r_pending    <= 1'b0;
        r_ovf        <= 1'b0;
        r_load       <= 1'b0;
        r_host_valid <= 1'b0;
      end else begin
        if (w_trig_hit) begin
          r_trig_addr <= w_wr_ptr;
          r_cnt       <= w_delay_clamp;
        end else if (w_trc_we && (r_state == SEQ_DELAY)) begin
          r_cnt <= r_cnt - AW'(1);
        end
        if (w_wr_wrap) r_wrapped <= 1'b1;
        if (w_fifo_wr && !w_fifo_rd)      r_count <= r_count + CW'(1);
        else if (w_fifo_rd && !w_fifo_wr) r_count <= r_count - CW'(1);
        if (w_fifo_rd)                    r_pending <= 1'b0;
        else if (w_stream_act && REQ_I)   r_pending <= 1'b1;
        if (w_stream_act && HOST_WE_I && w_full) r_ovf <= 1'b1;
        r_load       <= w_fifo_rd;
        r_host_valid <= w_host_rd;
      end
    end
  end

  // LOAD_O / HOST_VALID_O: single-cycle valid, no ready; data is the RAM read
  // port passed through during that cycle and zero otherwise.
  assign LOAD_O       = r_load;
  assign TRC_DATA_O   = r_load ? MEM_RDATA_I : '0;
  assign HOST_VALID_O = r_host_valid;
  assign HOST_DATA_O  = r_host_valid ? MEM_RDATA_I : '0;
  assign TRG_EVENT_O  = (r_state == SEQ_DONE);
  assign DONE_O       = (r_state == SEQ_DONE);
  assign TRIG_ADDR_O  = r_trig_addr;
  assign FULL_O       = r_mode_q & w_full;
  assign EMPTY_O      = ~r_mode_q | w_empty;
  assign OVF_O        = r_ovf;
  assign MEM_WE_O     = w_trc_we | w_fifo_wr;
  assign MEM_WADDR_O  = w_wr_ptr;
  assign MEM_WDATA_O  = w_trc_we ? TRC_DATA_I : (w_fifo_wr ? HOST_DATA_I : '0);
  assign MEM_RADDR_O  = w_rd_ptr;
  assign DBG_STATE_O  = r_state;
endmodule

// File: tb/tb_trb_mem_sequencer.sv
// Directed bench for trb_mem_sequencer with a behavioural 1-cycle-latency dual-port RAM.
module tb_trb_mem_sequencer;
  import dtb_pkg::*;
  localparam int AW = TRB_ADDR_BITS;
  localparam int W  = TRB_WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n, en_i, mode_i, clear_i, store_i, trig_i, req_i;
  logic [TRB_DELAY_BITS-1:0] delay_i;
  logic [W-1:0]              trc_data_i, host_data_i;
  logic                      host_we_i, host_re_i;
  logic                      trg_event_o, load_o, host_valid_o, full_o, empty_o, done_o, ovf_o, mem_we_o;
  logic [W-1:0]              trc_data_o, host_data_o, mem_wdata_o, mem_rdata;
  logic [AW-1:0]             trig_addr_o, mem_waddr_o, mem_raddr_o;
  seq_state_e                dbg_state;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [W-1:0] mem [TRB_DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we_o) begin
      mem[mem_waddr_o] <= mem_wdata_o;
      we_cnt <= we_cnt + 1;
    end
    mem_rdata <= mem[mem_raddr_o];
  end

  trb_mem_sequencer dut (
    .FPGA_CLK_I(clk), .RST_NI(rst_n), .EN_I(en_i), .MODE_I(mode_i), .CLEAR_I(clear_i),
    .DELAY_I(delay_i), .STORE_I(store_i), .TRC_DATA_I(trc_data_i), .TRIG_I(trig_i), .REQ_I(req_i),
    .TRG_EVENT_O(trg_event_o), .LOAD_O(load_o), .TRC_DATA_O(trc_data_o),
    .HOST_WE_I(host_we_i), .HOST_DATA_I(host_data_i), .HOST_RE_I(host_re_i),
    .HOST_DATA_O(host_data_o), .HOST_VALID_O(host_valid_o), .TRIG_ADDR_O(trig_addr_o),
    .FULL_O(full_o), .EMPTY_O(empty_o), .DONE_O(done_o), .OVF_O(ovf_o),
    .MEM_WE_O(mem_we_o), .MEM_WADDR_O(mem_waddr_o), .MEM_WDATA_O(mem_wdata_o),
    .MEM_RADDR_O(mem_raddr_o), .MEM_RDATA_I(mem_rdata), .DBG_STATE_O(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en_i = 1'b0; mode_i = 1'b0; clear_i = 1'b0; delay_i = '0;
    store_i = 1'b0; trig_i = 1'b0; req_i = 1'b0; trc_data_i = '0;
    host_we_i = 1'b0; host_re_i = 1'b0; host_data_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic store(input logic [W-1:0] d, input logic trg);
    store_i = 1'b1; trc_data_i = d; trig_i = trg;
    tick();
    store_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({trg_event_o, load_o, host_valid_o, full_o, empty_o, done_o, ovf_o, mem_we_o} !== 8'b0000_1000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00001000",
               {trg_event_o, load_o, host_valid_o, full_o, empty_o, done_o, ovf_o, mem_we_o});
    end
    checks++;
    if ({trig_addr_o, mem_waddr_o, mem_raddr_o, trc_data_o, host_data_o} !== '0 || dbg_state !== SEQ_IDLE) begin
      errors++;
      $display("FAIL reset_regs: trig=%0d wa=%0d ra=%0d state=%0d expected all 0/IDLE",
               trig_addr_o, mem_waddr_o, mem_raddr_o, dbg_state);
    end
  endtask

  task automatic test_trace_delay();
    int w0;
    apply_reset();
    delay_i = 8'd3; en_i = 1'b1;
    tick();
    checks++;
    if (dbg_state !== SEQ_ARMED) begin
      errors++; $display("FAIL t1_armed: got %0d expected %0d", dbg_state, SEQ_ARMED);
    end
    w0 = we_cnt;
    for (int i = 0; i < 13; i++) begin
      store(W'(32'hA000_0000 + i), (i >= 9));
      if (i == 9) begin
        checks++;
        if (trig_addr_o !== AW'(9) || dbg_state !== SEQ_DELAY) begin
          errors++; $display("FAIL t1_trig: addr=%0d state=%0d expected 9/DELAY", trig_addr_o, dbg_state);
        end
      end
      if (i == 11) begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++; $display("FAIL t1_early_done: got %b expected 0", done_o);
        end
      end
    end
    checks++;
    if ({done_o, trg_event_o} !== 2'b11) begin
      errors++; $display("FAIL t1_done: got %b expected 11", {done_o, trg_event_o});
    end
    checks++;
    if (we_cnt - w0 !== 13) begin
      errors++; $display("FAIL t1_wcount: got %0d expected 13", we_cnt - w0);
    end
    checks++;
    if (mem[9] !== 32'hA000_0009 || mem[12] !== 32'hA000_000C) begin
      errors++; $display("FAIL t1_ram: m9=%h m12=%h expected a0000009/a000000c", mem[9], mem[12]);
    end
    store_i = 1'b1;
    #1;
    checks++;
    if (mem_we_o !== 1'b0) begin
      errors++; $display("FAIL t1_done_store: we=%b expected 0", mem_we_o);
    end
    tick();
    store_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0; trig_i = 1'b0;
    checks++;
    if (done_o !== 1'b0 || trig_addr_o !== '0 || dbg_state !== SEQ_IDLE) begin
      errors++; $display("FAIL t1_clear: done=%b trig=%0d state=%0d expected 0/0/IDLE", done_o, trig_addr_o, dbg_state);
    end
  endtask

  task automatic test_trace_wrap();
    logic [W-1:0] exp;
    int bad;
    apply_reset();
    delay_i = 8'd0; en_i = 1'b1;
    tick();
    for (int i = 0; i <= 100; i++) store(W'(32'hB000_0000 + i), (i == 100));
    trig_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || trig_addr_o !== AW'(36) || mem_raddr_o !== AW'(37)) begin
      errors++; $display("FAIL t2_freeze: done=%b trig=%0d ra=%0d expected 1/36/37", done_o, trig_addr_o, mem_raddr_o);
    end
    bad = 0;
    host_re_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      exp = W'(32'hB000_0000 + 37 + i);
      checks++;
      if ({host_valid_o, host_data_o} !== {1'b1, exp}) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL t2_read%0d: got v=%b d=%h expected v=1 d=%h", i, host_valid_o, host_data_o, exp);
      end
    end
    host_re_i = 1'b0;
    tick();
    checks++;
    if (host_valid_o !== 1'b0) begin
      errors++; $display("FAIL t2_valid_end: got %b expected 0", host_valid_o);
    end
  endtask

  task automatic test_trace_clamp();
    apply_reset();
    delay_i = 8'd200; en_i = 1'b1;
    tick();
    for (int i = 0; i <= 68; i++) begin
      store(W'(32'hC000_0000 + i), (i >= 5));
      if (i == 67) begin
        checks++;
        if (done_o !== 1'b0) begin
          errors++; $display("FAIL t3_early_done: got %b expected 0", done_o);
        end
      end
    end
    trig_i = 1'b0;
    checks++;
    if ({trg_event_o, done_o} !== 2'b11 || trig_addr_o !== AW'(5)) begin
      errors++; $display("FAIL t3_done: ev=%b done=%b trig=%0d expected 1/1/5", trg_event_o, done_o, trig_addr_o);
    end
    checks++;
    if (mem[5] !== 32'hC000_0005 || mem[4] !== 32'hC000_0044 || mem_raddr_o !== AW'(5)) begin
      errors++; $display("FAIL t3_ram: m5=%h m4=%h ra=%0d expected c0000005/c0000044/5", mem[5], mem[4], mem_raddr_o);
    end
  endtask

  task automatic test_stream_full();
    int w0;
    apply_reset();
    mode_i = 1'b1; en_i = 1'b1;
    tick();
    checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      errors++; $display("FAIL t4_empty: e=%b f=%b expected 1/0", empty_o, full_o);
    end
    w0 = we_cnt;
    host_we_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      host_data_i = W'(32'hD000_0000 + i);
      tick();
      if (i == 62) begin
        checks++;
        if (full_o !== 1'b0) begin
          errors++; $display("FAIL t4_full63: got %b expected 0", full_o);
        end
      end
    end
    host_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (full_o !== 1'b1 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL t4_full64: f=%b we=%b expected 1/0", full_o, mem_we_o);
    end
    tick();
    host_we_i = 1'b0;
    checks++;
    if (ovf_o !== 1'b1 || full_o !== 1'b1 || we_cnt - w0 !== 64) begin
      errors++; $display("FAIL t4_ovf: ovf=%b f=%b writes=%0d expected 1/1/64", ovf_o, full_o, we_cnt - w0);
    end
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    checks++;
    if (load_o !== 1'b0) begin
      errors++; $display("FAIL t4_load_early: got %b expected 0", load_o);
    end
    tick();
    checks++;
    if ({load_o, trc_data_o} !== {1'b1, 32'hD000_0000} || full_o !== 1'b0) begin
      errors++; $display("FAIL t4_load: l=%b d=%h f=%b expected 1/d0000000/0", load_o, trc_data_o, full_o);
    end
    tick();
    checks++;
    if (load_o !== 1'b0) begin
      errors++; $display("FAIL t4_load_pulse: got %b expected 0", load_o);
    end
  endtask

  task automatic test_stream_wait();
    int seen;
    apply_reset();
    mode_i = 1'b1; en_i = 1'b1;
    tick();
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if (load_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL t5_empty_wait: loads=%0d expected 0", seen);
    end
    host_we_i = 1'b1; host_data_i = 32'h0000_0055;
    tick();
    host_we_i = 1'b0;
    checks++;
    if (load_o !== 1'b0) begin
      errors++; $display("FAIL t5_no_bypass: got %b expected 0", load_o);
    end
    tick();
    checks++;
    if ({load_o, trc_data_o} !== {1'b1, 32'h0000_0055}) begin
      errors++; $display("FAIL t5_load: l=%b d=%h expected 1/00000055", load_o, trc_data_o);
    end
    seen = 0;
    repeat (4) begin
      tick();
      if (load_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL t5_single: extra=%0d empty=%b expected 0/1", seen, empty_o);
    end
    host_we_i = 1'b1; host_data_i = 32'h0000_0077; req_i = 1'b1;
    tick();
    host_we_i = 1'b0; req_i = 1'b0;
    checks++;
    if (load_o !== 1'b0) begin
      errors++; $display("FAIL t5_same_cycle_early: got %b expected 0", load_o);
    end
    tick();
    checks++;
    if ({load_o, trc_data_o} !== {1'b1, 32'h0000_0077}) begin
      errors++; $display("FAIL t5_same_cycle: l=%b d=%h expected 1/00000077", load_o, trc_data_o);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    mode_i = 1'b1; en_i = 1'b1;
    tick();
    host_we_i = 1'b1; host_data_i = 32'h0000_00E1;
    tick();
    host_we_i = 1'b0; req_i = 1'b1;
    tick();
    req_i = 1'b0; en_i = 1'b0;
    tick();
    checks++;
    if (load_o !== 1'b0 || empty_o !== 1'b0) begin
      errors++; $display("FAIL en_hold: l=%b e=%b expected 0/0", load_o, empty_o);
    end
    host_we_i = 1'b1; host_data_i = 32'h0000_00E2;
    #1;
    checks++;
    if (mem_we_o !== 1'b0) begin
      errors++; $display("FAIL en_no_write: got %b expected 0", mem_we_o);
    end
    tick();
    host_we_i = 1'b0; en_i = 1'b1;
    tick();
    en_i = 1'b0;
    checks++;
    if ({load_o, trc_data_o} !== {1'b1, 32'h0000_00E1}) begin
      errors++; $display("FAIL en_pulse: l=%b d=%h expected 1/000000e1", load_o, trc_data_o);
    end
    tick();
    checks++;
    if (load_o !== 1'b0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL en_drain: l=%b e=%b expected 0/1", load_o, empty_o);
    end
  endtask

  task automatic test_restart();
    int w0;
    apply_reset();
    delay_i = 8'd10; en_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) store(W'(32'hF000_0000 + i), (i >= 2));
    checks++;
    if (dbg_state !== SEQ_DELAY) begin
      errors++; $display("FAIL t6_delay: got %0d expected %0d", dbg_state, SEQ_DELAY);
    end
    store_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({trg_event_o, load_o, host_valid_o, full_o, empty_o, done_o, ovf_o, mem_we_o} !== 8'b0000_1000 ||
        trig_addr_o !== '0 || dbg_state !== SEQ_IDLE) begin
      errors++; $display("FAIL t6_async_rst: flags=%b trig=%0d state=%0d",
                         {trg_event_o, load_o, host_valid_o, full_o, empty_o, done_o, ovf_o, mem_we_o}, trig_addr_o, dbg_state);
    end
    w0 = we_cnt;
    repeat (2) tick();
    checks++;
    if (we_cnt !== w0) begin
      errors++; $display("FAIL t6_rst_writes: got %0d expected 0", we_cnt - w0);
    end
    store_i = 1'b0; trig_i = 1'b0; rst_n = 1'b1;
    mode_i = 1'b1;
    tick();
    host_we_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_data_i = W'(i);
      tick();
    end
    checks++;
    if (empty_o !== 1'b0) begin
      errors++; $display("FAIL t6_stream_fill: empty=%b expected 0", empty_o);
    end
    mode_i = 1'b0;
    #1;
    checks++;
    if (mem_we_o !== 1'b0) begin
      errors++; $display("FAIL t6_toggle_write: got %b expected 0", mem_we_o);
    end
    tick();
    host_we_i = 1'b0;
    checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || ovf_o !== 1'b0 || mem_waddr_o !== '0 || dbg_state !== SEQ_IDLE) begin
      errors++; $display("FAIL t6_toggle: e=%b f=%b ovf=%b wa=%0d state=%0d expected 1/0/0/0/IDLE",
                         empty_o, full_o, ovf_o, mem_waddr_o, dbg_state);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trace_delay();
    test_trace_wrap();
    test_trace_clamp();
    test_stream_full();
    test_stream_wait();
    test_enable();
    test_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
